// File: rtl/data_mem_sram_ctrl_if.sv
// data_mem_sram_ctrl_if: MEM-stage command bus plus SRAM pin bundle
interface data_mem_sram_ctrl_if #(
  parameter int SRAM_AW = 17
);
  logic               mem_r_en;
  logic               mem_w_en;
  logic [31:0]        address;
  logic [31:0]        st_value;
  logic [31:0]        mem_out;
  logic               ready;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;
  logic               sram_we_n;
  logic               sram_oe_n;
  logic               sram_ce_n;
  modport master (
    output mem_r_en, mem_w_en, address, st_value, sram_rdata,
    input  mem_out, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n, sram_ce_n
  );
  modport slave (
    input  mem_r_en, mem_w_en, address, st_value, sram_rdata,
    output mem_out, ready, sram_addr, sram_wdata, sram_we_n, sram_oe_n, sram_ce_n
  );
endinterface

// File: rtl/data_mem_sram_ctrl.sv
// data_mem_sram_ctrl: sequences MEM-stage loads/stores onto an async SRAM with fixed wait states
module data_mem_sram_ctrl #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 17
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_sram_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        mem_out_q, mem_out_d;
  logic               we_q, we_d;
  logic               req;
  assign req = bus.mem_r_en | bus.mem_w_en;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_out_q <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_out_q <= mem_out_d;
      we_q      <= we_d;
    end
  end
  // Address/data/op are captured only in IDLE so ACCESS is immune to input changes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_out_d = mem_out_q;
    we_d      = we_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d  = SRAM_AW'((bus.address - BASE_ADDR) >> 2);
        wdata_d = bus.st_value;
        we_d    = bus.mem_w_en;
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d   = DONE;
          mem_out_d = we_q ? mem_out_q : bus.sram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Strobes decode straight from state so reset releases them asynchronously
  assign bus.ready      = (state_q == DONE) || (state_q == IDLE && !req);
  assign bus.sram_ce_n  = state_q != ACCESS;
  assign bus.sram_we_n  = !(state_q == ACCESS && we_q);
  assign bus.sram_oe_n  = !(state_q == ACCESS && !we_q);
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.mem_out    = mem_out_q;
endmodule

// File: tb/tb_data_mem_sram_ctrl.sv
// tb_data_mem_sram_ctrl: randomized scoreboard bench with SRAM model and word-level reference memory
module tb_data_mem_sram_ctrl;
  localparam int W  = 5;
  localparam int AW = 17;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  data_mem_sram_ctrl_if #(.SRAM_AW(AW)) bus ();
  data_mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024), .SRAM_AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    bit          wr;
    logic [AW-1:0] word;
    logic [31:0] wdata;
    logic [31:0] mout;
  } exp_t;
  exp_t        q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          bcnt    = 0;
  logic [31:0] sram[int];
  logic [31:0] ref_mem[int];
  logic [31:0] last_read = '0;
  function automatic logic [31:0] init_val(input logic [AW-1:0] w);
    return ({15'd0, w} * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [AW-1:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'd1024) / 4;
    return off[AW-1:0];
  endfunction
  function automatic logic [31:0] sram_rd(input logic [AW-1:0] w);
    return sram.exists(int'(w)) ? sram[int'(w)] : init_val(w);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [AW-1:0] w);
    return ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : init_val(w);
  endfunction
  // Asynchronous SRAM: data while OE/CE low, write committed on rising WE
  assign bus.sram_rdata = (!bus.sram_oe_n && !bus.sram_ce_n) ? sram_rd(bus.sram_addr) : 32'h0;
  always @(posedge bus.sram_we_n)
    if (rst && $time > 0) sram[int'(bus.sram_addr)] = bus.sram_wdata;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      bcnt = 0;
    end else if (!bus.ready) begin
      bcnt++;
      if (q.size() == 0) chk("busy_without_request", 32'd1, 32'd0);
      else if (bcnt == 1) chk("request_cycle_strobes", {29'd0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'd7);
      else begin
        chk("access_strobes", {29'd0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, {29'd0, 1'b0, !q[0].wr, q[0].wr});
        chk("access_addr", {15'd0, bus.sram_addr}, {15'd0, q[0].word});
        if (q[0].wr) chk("access_wdata", bus.sram_wdata, q[0].wdata);
      end
    end else if (bcnt > 0) begin
      chk("latency", bcnt, W + 1);
      chk("done_strobes", {29'd0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'd7);
      if (q.size() > 0) begin
        chk("mem_out", bus.mem_out, q[0].mout);
        void'(q.pop_front());
      end
      bcnt = 0;
    end else chk("idle_strobes", {29'd0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'd7);
  end
  task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit noise);
    exp_t e;
    int   n;
    e.wr    = w;
    e.word  = word_of(a);
    e.wdata = d;
    if (w) ref_mem[int'(e.word)] = d;
    else last_read = ref_rd(e.word);
    e.mout = last_read;
    q.push_back(e);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address  = a;
    bus.st_value = d;
    n = 0;
    @(negedge clk);
    while (!bus.ready && n < 50) begin
      @(posedge clk); #1;
      if (noise) begin
        bus.mem_r_en = 1'($urandom);
        bus.mem_w_en = 1'($urandom);
        bus.address  = $urandom;
        bus.st_value = $urandom;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    time t0;
    logic [31:0] a, d;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = '0;
    bus.st_value = '0;
    sram[2]    = 32'hDEADBEEF;
    ref_mem[2] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_mem_out", bus.mem_out, 32'd0);
    chk("reset_ready", {31'd0, bus.ready}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    issue(1, 0, 32'd1032, 32'd0, 0);
    issue(0, 1, 32'd1424, 32'h12345678, 0);
    chk("sram_word100", sram_rd(17'd100), 32'h12345678);
    t0 = $time;
    issue(0, 1, 32'd1040, 32'hCAFEF00D, 0);
    issue(1, 0, 32'd1040, 32'd0, 0);
    chk("back_to_back_cycles", 32'(($time - t0) / 10), 32'd14);
    issue(1, 1, 32'd1028, 32'hA5A5_0001, 0);
    issue(1, 0, 32'd1028, 32'd0, 0);
    bus.mem_w_en = 1'b1;
    bus.address  = 32'd1100;
    bus.st_value = 32'h0BAD0BAD;
    begin
      exp_t e;
      e.wr = 1'b1; e.word = word_of(32'd1100); e.wdata = 32'h0BAD0BAD; e.mout = last_read;
      q.push_back(e);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_strobes", {29'd0, bus.sram_ce_n, bus.sram_we_n, bus.sram_oe_n}, 32'd7);
    chk("abort_mem_out", bus.mem_out, 32'd0);
    bus.mem_w_en = 1'b0;
    last_read = '0;
    @(posedge clk); #1 rst = 1'b1;
    chk("post_reset_ready", {31'd0, bus.ready}, 32'd1);
    @(posedge clk); #1;
    issue(1, 0, 32'd1032, 32'd0, 0);
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'd1024 + $urandom_range(0, 255) : $urandom;
      d = $urandom;
      case ($urandom_range(0, 2))
        0: issue(1, 0, a, d, 1'($urandom));
        1: issue(0, 1, a, d, 1'($urandom));
        default: issue(1, 1, a, d, 1'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_sram_ctrl.md
Name: data_mem_sram_ctrl

Overview:
- Sequences MEM-stage data accesses onto an external asynchronous SRAM with fixed wait states.
- Sits between the MEM stage and the SRAM pins.
- Converts single-cycle read/write commands into multi-cycle SRAM transactions.
- Drives a `ready` signal. The hazard/freeze logic uses `ready` to stall all pipeline registers while an access is in flight.

Parameters:
- WAIT_CYCLES, 5, number of cycles SRAM strobes and address are held per access; legal range 1..15.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 17, SRAM word-address width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- mem_r_en  input  1  MEM-stage read command
- mem_w_en  input  1  MEM-stage write command
- address  input  32  byte address (ALU result)
- st_value  input  32  store data
- mem_out  output  32  load data to WB path
- ready  output  1  1 = MEM stage may advance; 0 = freeze pipeline
- sram_addr  output  SRAM_AW  SRAM word address
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  32  SRAM read data
- sram_we_n  output  1  SRAM write strobe, active low
- sram_oe_n  output  1  SRAM output enable, active low
- sram_ce_n  output  1  SRAM chip enable, active low

Behaviour:

Reset (rst=0, asynchronous):
- state=IDLE, counter=0, mem_out=0.
- sram_addr=0, sram_wdata=0.
- sram_we_n=1, sram_oe_n=1, sram_ce_n=1.

Address mapping:
- word = (address − BASE_ADDR) >> 2, truncated to SRAM_AW bits, 32-bit wrap on subtraction.
- address[1:0] is ignored.

State IDLE:
- No request: ready=1 (combinational), strobes inactive.
- Request (mem_r_en|mem_w_en)=1:
  - ready=0 combinationally in the same cycle.
  - Latch mapped address, st_value, and op.
  - If both enables are 1, the op is a write.
  - Clear counter; next state ACCESS.

State ACCESS:
- Lasts exactly WAIT_CYCLES cycles; ready=0.
- sram_ce_n=0 throughout.
- Write: sram_we_n=0, sram_oe_n=1.
- Read: sram_oe_n=0, sram_we_n=1.
- sram_addr and sram_wdata hold the latched values and are stable for the whole state.
- Counter increments each cycle. When counter==WAIT_CYCLES−1:
  - For a read, register sram_rdata into mem_out.
  - Next state DONE.

State DONE:
- One cycle; ready=1; all strobes inactive.
- mem_out valid.
- Next state IDLE unconditionally. The still-present command is the same frozen instruction and is ignored; the pipeline advances on this edge.

Latency:
- Request seen in cycle 0; ready=0 in cycles 0..WAIT_CYCLES; ready=1 in cycle WAIT_CYCLES+1.
- Total cost is WAIT_CYCLES+2 cycles, including the DONE cycle.

mem_out:
- Updated only on read completion.
- Held through writes and idle cycles.

Boundary conditions:
- Enables deasserted mid-access: the transaction still completes with the latched values; no abort.
- Enables or address changing during ACCESS: ignored.
- Back-to-back requests: a request present in the first IDLE cycle after DONE starts a new transaction immediately. There is no extra bubble beyond DONE→IDLE.
- Reset asserted mid-ACCESS: immediate return to reset values, strobes deassert asynchronously, and the write is not guaranteed.
- WAIT_CYCLES=1: ACCESS lasts one cycle.

Test Plan:
1. Idle: rst released, no enables for 10 cycles -> ready=1, sram_ce_n/we_n/oe_n=1, mem_out=0.
2. Read, WAIT_CYCLES=5:
   - Stimulus: address=1032, SRAM model word 2=0xDEADBEEF.
   - Response: sram_addr=2; oe_n=0 for cycles 1..5; ready=0 for cycles 0..5 and 1 in cycle 6; mem_out=0xDEADBEEF from cycle 6.
3. Write:
   - Stimulus: address=1024+400, st_value=0x12345678.
   - Response: sram_addr=100; we_n=0 for exactly 5 cycles with wdata stable; the model holds 0x12345678; mem_out is unchanged.
4. Back-to-back write then read of the same address 1040 -> second transaction starts the cycle after DONE; read returns the written value; total 14 cycles.
5. Simultaneous mem_r_en=mem_w_en=1 at address 1028 -> write to word 1 performed; oe_n stays 1.
6. rst pulsed low in the 3rd ACCESS cycle of a write -> all strobes high within the same cycle; state IDLE; ready=1 after release; a subsequent read completes normally.
